// File: rtl/id_ex_pkg.sv
// Shared definitions for the decode stage: opcode values, instruction field
// positions and the per-instruction control bundle.
package id_ex_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;

  // Field positions (lsb) within the 32-bit instruction word
  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 25;
  localparam int RS1_LSB = 22;
  localparam int RS2_LSB = 19;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic wena;
    logic memrd;
    logic memwr;
  } decode_ctrl_t;

endpackage

// File: rtl/id_ex_stage_instr_decoder.sv
// Combinational opcode decode and immediate sign extension.
module instr_decoder
  import id_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [3:0]        op,
  input  logic [IMM_W-1:0]  imm,
  output logic [3:0]        op_dec,
  output decode_ctrl_t      ctrl,
  output logic [DATA_W-1:0] imm_ext
);

  // Map opcode to its control bundle; unknown opcodes become a plain NOP
  always_comb begin
    ctrl   = '0;
    op_dec = op;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        ctrl.uses_rs1 = 1'b1;
        ctrl.uses_rs2 = 1'b1;
        ctrl.wena     = 1'b1;
      end
      OP_ADDI: begin
        ctrl.uses_rs1 = 1'b1;
        ctrl.wena     = 1'b1;
      end
      OP_LW: begin
        ctrl.uses_rs1 = 1'b1;
        ctrl.wena     = 1'b1;
        ctrl.memrd    = 1'b1;
      end
      OP_SW: begin
        ctrl.uses_rs1 = 1'b1;
        ctrl.uses_rs2 = 1'b1;
        ctrl.memwr    = 1'b1;
      end
      OP_BEQ: begin
        ctrl.uses_rs1 = 1'b1;
        ctrl.uses_rs2 = 1'b1;
      end
      OP_NOP: ;
      default: op_dec = OP_NOP;
    endcase
  end

  assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with ID/EX pipeline register, load-use hazard detection
// and branch flush handling.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_instr,
  output logic              id_stall,
  output logic [ADDR_W-1:0] r1addr,
  output logic [ADDR_W-1:0] r2addr,
  input  logic [DATA_W-1:0] r1data,
  input  logic [DATA_W-1:0] r2data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [3:0]        ex_op,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [ADDR_W-1:0] ex_rs1,
  output logic [ADDR_W-1:0] ex_rs2,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_wena,
  output logic              ex_memrd,
  output logic              ex_memwr
);

  logic [3:0]        op;
  logic [3:0]        op_dec;
  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_ext;
  decode_ctrl_t      ctrl;
  logic              haz;
  logic              unused_bits;

  assign op  = id_instr[OP_LSB +: 4];
  assign rd  = id_instr[RD_LSB +: ADDR_W];
  assign rs1 = id_instr[RS1_LSB +: ADDR_W];
  assign rs2 = id_instr[RS2_LSB +: ADDR_W];
  assign imm = id_instr[IMM_LSB +: IMM_W];

  // Bits between rs2 and the immediate carry no meaning in this format
  assign unused_bits = ^id_instr[RS2_LSB-1:IMM_W];

  // Read addresses follow the fields even for invalid slots
  assign r1addr = rs1;
  assign r2addr = rs2;

  instr_decoder #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_dec (
    .op      (op),
    .imm     (imm),
    .op_dec  (op_dec),
    .ctrl    (ctrl),
    .imm_ext (imm_ext)
  );

  // r0 is an ordinary register here, so no zero-register exemption
  assign haz = id_valid & ex_valid & ex_memrd &
               ((ctrl.uses_rs1 & (rs1 == ex_rd)) |
                (ctrl.uses_rs2 & (rs2 == ex_rd)));

  assign id_stall = (haz | ex_stall) & ~flush;

  // ID/EX latch: flush and load-use both leave a zeroed bubble behind
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_rd    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_wena  <= 1'b0;
      ex_memrd <= 1'b0;
      ex_memwr <= 1'b0;
    end else if (flush || (haz && !ex_stall)) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_rd    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_wena  <= 1'b0;
      ex_memrd <= 1'b0;
      ex_memwr <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid <= id_valid;
      ex_op    <= op_dec;
      ex_rd    <= rd;
      ex_rs1   <= rs1;
      ex_rs2   <= rs2;
      ex_a     <= r1data;
      ex_b     <= r2data;
      ex_imm   <= imm_ext;
      ex_wena  <= id_valid & ctrl.wena;
      ex_memrd <= id_valid & ctrl.memrd;
      ex_memwr <= id_valid & ctrl.memwr;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: an instruction-level reference of the ID/EX slot
// compared every cycle, plus directed scenarios with literal expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic        id_stall;
  logic [2:0]  r1addr, r2addr;
  logic [31:0] r1data = '0, r2data = '0;
  logic        ex_stall = 1'b0, flush = 1'b0;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [2:0]  ex_rd, ex_rs1, ex_rs2;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic        ex_wena, ex_memrd, ex_memwr;

  int pass_cnt = 0;
  int total_cnt = 0;

  id_ex_stage dut (
    .clk(clk), .clr(clr), .id_valid(id_valid), .id_instr(id_instr),
    .id_stall(id_stall), .r1addr(r1addr), .r2addr(r2addr),
    .r1data(r1data), .r2data(r2data), .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_wena(ex_wena), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input logic [15:0] imm);
    enc = {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], 3'b000, imm};
  endfunction

  // Instruction table: {uses_rs1, uses_rs2, wena, memrd, memwr}
  function automatic logic [4:0] info(input logic [3:0] op);
    case (op)
      1, 2, 3, 4, 5: info = 5'b11100;
      6:             info = 5'b10100;
      7:             info = 5'b10110;
      8:             info = 5'b11001;
      9:             info = 5'b11000;
      default:       info = 5'b00000;
    endcase
  endfunction

  // Reference contents of the ID/EX slot
  logic        m_valid = 0, m_wena = 0, m_memrd = 0, m_memwr = 0;
  logic [3:0]  m_op = 0;
  logic [2:0]  m_rd = 0, m_rs1 = 0, m_rs2 = 0;
  logic [31:0] m_a = 0, m_b = 0, m_imm = 0;

  function automatic logic model_haz();
    logic [4:0] f;
    f = info(id_instr[31:28]);
    model_haz = id_valid && m_valid && m_memrd &&
                ((f[4] && id_instr[24:22] == m_rd) || (f[3] && id_instr[21:19] == m_rd));
  endfunction

  always @(posedge clk or posedge clr) begin
    logic [4:0] f;
    logic       h;
    if (clr) begin
      m_valid = 0; m_wena = 0; m_memrd = 0; m_memwr = 0;
      m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_a = 0; m_b = 0; m_imm = 0;
    end else begin
      h = model_haz();
      f = info(id_instr[31:28]);
      if (flush || (h && !ex_stall)) begin
        m_valid = 0; m_wena = 0; m_memrd = 0; m_memwr = 0;
      end else if (!ex_stall) begin
        m_valid = id_valid;
        m_op    = (id_instr[31:28] <= 4'd9) ? id_instr[31:28] : 4'd0;
        m_rd    = id_instr[27:25];
        m_rs1   = id_instr[24:22];
        m_rs2   = id_instr[21:19];
        m_a     = r1data;
        m_b     = r2data;
        m_imm   = {{16{id_instr[15]}}, id_instr[15:0]};
        m_wena  = id_valid && f[2];
        m_memrd = id_valid && f[1];
        m_memwr = id_valid && f[0];
      end
    end
  end

  // Per-cycle comparison against the reference, away from the active edge
  always @(negedge clk) begin
    chk("m_r1addr", {29'd0, r1addr}, {29'd0, id_instr[24:22]});
    chk("m_r2addr", {29'd0, r2addr}, {29'd0, id_instr[21:19]});
    chk("m_id_stall", {31'd0, id_stall},
        {31'd0, !clr && (model_haz() || ex_stall) && !flush});
    chk("m_ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("m_ctrl", {29'd0, ex_wena, ex_memrd, ex_memwr}, {29'd0, m_wena, m_memrd, m_memwr});
    if (m_valid) begin
      chk("m_ex_op", {28'd0, ex_op}, {28'd0, m_op});
      chk("m_ex_regs", {23'd0, ex_rd, ex_rs1, ex_rs2}, {23'd0, m_rd, m_rs1, m_rs2});
      chk("m_ex_a", ex_a, m_a);
      chk("m_ex_b", ex_b, m_b);
      chk("m_ex_imm", ex_imm, m_imm);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic st, input logic fl);
    id_valid = v; id_instr = ins; r1data = a; r2data = b; ex_stall = st; flush = fl;
    #1;
  endtask

  initial begin
    clr = 1'b1;
    tick(); tick();
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    clr = 1'b0;
    tick();

    // ADD r3,r1,r2
    drive(1, enc(1, 3, 1, 2, 16'h0), 32'd5, 32'd7, 0, 0);
    chk("add_r1addr", {29'd0, r1addr}, 32'd1);
    chk("add_r2addr", {29'd0, r2addr}, 32'd2);
    tick();
    chk("add_valid", {31'd0, ex_valid}, 32'd1);
    chk("add_op", {28'd0, ex_op}, 32'd1);
    chk("add_rd", {29'd0, ex_rd}, 32'd3);
    chk("add_a", ex_a, 32'd5);
    chk("add_b", ex_b, 32'd7);
    chk("add_wena", {31'd0, ex_wena}, 32'd1);

    // LW r2 then dependent ADD r4,r2,r1 -> one bubble
    drive(1, enc(7, 2, 6, 0, 16'h4), 32'h100, 32'h0, 0, 0);
    tick();
    chk("lw_memrd", {31'd0, ex_memrd}, 32'd1);
    drive(1, enc(1, 4, 2, 1, 16'h0), 32'h9, 32'h3, 0, 0);
    chk("luse_stall", {31'd0, id_stall}, 32'd1);
    tick();
    chk("luse_bubble", {31'd0, ex_valid}, 32'd0);
    chk("luse_bubble_wena", {31'd0, ex_wena}, 32'd0);
    chk("luse_release", {31'd0, id_stall}, 32'd0);
    tick();
    chk("luse_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("luse_add_rd", {29'd0, ex_rd}, 32'd4);

    // LW r2 then ADDI r4,r5 (rs2 field happens to be r2 but is unused)
    drive(1, enc(7, 2, 6, 0, 16'h0), 32'h0, 32'h0, 0, 0);
    tick();
    drive(1, enc(6, 4, 5, 2, 16'hFFFE), 32'h20, 32'h0, 0, 0);
    chk("addi_nostall", {31'd0, id_stall}, 32'd0);
    tick();
    chk("addi_valid", {31'd0, ex_valid}, 32'd1);
    chk("addi_imm", ex_imm, 32'hFFFF_FFFE);

    // Flush together with load-use hazard and ex_stall
    drive(1, enc(7, 3, 1, 0, 16'h8), 32'h0, 32'h0, 0, 0);
    tick();
    drive(1, enc(1, 1, 3, 3, 16'h0), 32'h0, 32'h0, 1, 1);
    chk("flush_stall", {31'd0, id_stall}, 32'd0);
    tick();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_memrd", {31'd0, ex_memrd}, 32'd0);

    // SUB latched, then ex_stall held for three cycles
    drive(1, enc(2, 5, 1, 2, 16'h0), 32'h11, 32'h22, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, enc(5, 6, 3, 4, 16'h0), 32'h33, 32'h44, 1, 0);
      chk("hold_stall", {31'd0, id_stall}, 32'd1);
      tick();
      chk("hold_op", {28'd0, ex_op}, 32'd2);
      chk("hold_rd", {29'd0, ex_rd}, 32'd5);
      chk("hold_a", ex_a, 32'h11);
      chk("hold_b", ex_b, 32'h22);
    end
    drive(1, enc(5, 6, 3, 4, 16'h0), 32'h33, 32'h44, 0, 0);
    tick();
    chk("rel_op", {28'd0, ex_op}, 32'd5);
    chk("rel_a", ex_a, 32'h33);

    // Undefined opcode and invalid slot
    drive(1, enc(12, 1, 1, 1, 16'h0), 32'h0, 32'h0, 0, 0);
    tick();
    chk("undef_op", {28'd0, ex_op}, 32'd0);
    chk("undef_ctrl", {29'd0, ex_wena, ex_memrd, ex_memwr}, 32'd0);
    drive(0, enc(1, 2, 3, 4, 16'h0), 32'h0, 32'h0, 0, 0);
    tick();
    chk("inv_valid", {31'd0, ex_valid}, 32'd0);
    chk("inv_wena", {31'd0, ex_wena}, 32'd0);

    // r0 participates in the hazard compare (via rs2 of a store)
    drive(1, enc(7, 0, 1, 0, 16'h0), 32'h0, 32'h0, 0, 0);
    tick();
    drive(1, enc(8, 0, 7, 0, 16'h10), 32'h1, 32'h2, 0, 0);
    chk("r0_haz", {31'd0, id_stall}, 32'd1);
    tick();
    tick();
    chk("sw_memwr", {31'd0, ex_memwr}, 32'd1);
    drive(1, enc(9, 0, 2, 3, 16'h8000), 32'h0, 32'h0, 0, 0);
    tick();
    chk("beq_imm", ex_imm, 32'hFFFF_8000);
    chk("beq_wena", {31'd0, ex_wena}, 32'd0);

    // Asynchronous clear mid-stream
    drive(1, enc(1, 7, 1, 1, 16'h0), 32'hAA, 32'hBB, 0, 0);
    tick();
    chk("pre_clr_valid", {31'd0, ex_valid}, 32'd1);
    clr = 1'b1;
    #1;
    chk("clr_valid", {31'd0, ex_valid}, 32'd0);
    chk("clr_wena", {31'd0, ex_wena}, 32'd0);
    chk("clr_a", ex_a, 32'd0);
    chk("clr_op", {28'd0, ex_op}, 32'd0);
    chk("clr_stall", {31'd0, id_stall}, 32'd0);
    tick();
    clr = 1'b0;
    drive(0, 32'h0, 32'h0, 32'h0, 0, 0);
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
